// File: rtl/cmip_pkt_chk_easy_if.sv
// AXI-stream beat channel between the packet generator and the checker.
interface cmip_pkt_chk_easy_if #(
  parameter int DATA_WD = 32
);
  logic [DATA_WD-1:0]   tdata;
  logic [DATA_WD/8-1:0] tkeep;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic                 tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/cmip_pkt_chk_easy.sv
// Packet checker for the easy generator: verifies length, SOP, keep and
// payload pattern of every accepted beat and keeps saturating status counters.
module cmip_pkt_chk_easy #(
  parameter int DATA_WD = 32,
  parameter int CFG_WD  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_rst,
  input  logic [CFG_WD-1:0] cfg_len,
  input  logic [CFG_WD-1:0] cfg_mode,
  cmip_pkt_chk_easy_if.slave s_axis,
  output logic [CFG_WD-1:0] sts_pkt_cnt,
  output logic [CFG_WD-1:0] sts_err_pkt_cnt,
  output logic [CFG_WD-1:0] sts_len_err_cnt,
  output logic [CFG_WD-1:0] sts_data_err_cnt,
  output logic              sts_err,
  output logic              sts_err_pulse,
  output logic              sts_busy
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        bp;
  logic [31:0]       exp32;
  logic [CFG_WD-1:0] idx;
  logic              pkt_err;
  logic              len_flag;

  logic              clr;
  logic              beat;
  logic              mode_cnt;
  logic              mode_bp;
  logic [CFG_WD-1:0] len_imp;
  logic [CFG_WD-1:0] cur_idx;
  logic              pkt_err_cur;
  logic              len_flag_cur;
  logic [31:0]       exp_data;
  logic              data_err;
  logic              len_err;
  logic              beat_err;
  logic              unused_mode;

  function automatic logic [CFG_WD-1:0] sat_inc(input logic [CFG_WD-1:0] v);
    return (&v) ? v : v + CFG_WD'(1);
  endfunction

  assign clr         = rst | cfg_rst;
  assign mode_cnt    = cfg_mode[1];
  assign mode_bp     = cfg_mode[2];
  assign unused_mode = ^{cfg_mode[CFG_WD-1:3], cfg_mode[0]};
  assign beat        = s_axis.tvalid & s_axis.tready;
  assign len_imp     = (cfg_len == '0) ? CFG_WD'(8) : cfg_len;

  // The first beat of a packet is always checked at index 0, whatever the
  // per-packet registers hold, so a discarded packet cannot leak into the next.
  assign cur_idx      = (state == IDLE) ? '0 : idx;
  assign pkt_err_cur  = (state == PKT) & pkt_err;
  assign len_flag_cur = (state == PKT) & len_flag;

  assign exp_data = mode_cnt ? exp32 : cur_idx[31:0];
  assign data_err = (s_axis.tdata[31:0] != exp_data)
                  | ~(&s_axis.tkeep)
                  | (s_axis.tuser != (cur_idx == '0));
  // One length error per packet: short on an early tlast, long on the
  // last expected beat arriving without tlast.
  assign len_err  = ~len_flag_cur &
                    (( s_axis.tlast & (cur_idx <  len_imp - CFG_WD'(1))) |
                     (~s_axis.tlast & (cur_idx == len_imp - CFG_WD'(1))));
  assign beat_err = data_err | len_err;

  assign s_axis.tready = ~rst & ~cfg_rst & ~(mode_bp & (bp == 2'd3));
  assign sts_busy      = (state == PKT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: any accepted beat enters PKT unless it carries tlast.
  always_comb begin
    // NOTE: default first, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE: if (beat) state_nxt = s_axis.tlast ? IDLE : PKT;
      PKT:  if (beat && s_axis.tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Free-running backpressure phase; held at 0 when throttling is off.
  always_ff @(posedge clk) begin
    if (clr || !mode_bp) bp <= 2'd0;
    else                 bp <= bp + 2'd1;
  end

  // Running-counter expectation; reloading from received+1 equals
  // incrementing on a match and resynchronises after a gap.
  always_ff @(posedge clk) begin
    if (clr || !mode_cnt) exp32 <= 32'd0;
    else if (beat)        exp32 <= s_axis.tdata[31:0] + 32'd1;
  end

  // Per-packet beat index and error flags, cleared at packet end.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx      <= '0;
      pkt_err  <= 1'b0;
      len_flag <= 1'b0;
    end else if (beat) begin
      if (s_axis.tlast) begin
        idx      <= '0;
        pkt_err  <= 1'b0;
        len_flag <= 1'b0;
      end else begin
        idx      <= sat_inc(cur_idx);
        pkt_err  <= pkt_err_cur | beat_err;
        len_flag <= len_flag_cur | len_err;
      end
    end
  end

  // Registered status: saturating counters, sticky flag and per-beat pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      sts_pkt_cnt      <= '0;
      sts_err_pkt_cnt  <= '0;
      sts_len_err_cnt  <= '0;
      sts_data_err_cnt <= '0;
      sts_err          <= 1'b0;
      sts_err_pulse    <= 1'b0;
    end else begin
      sts_err_pulse <= beat & beat_err;
      if (beat) begin
        if (data_err) sts_data_err_cnt <= sat_inc(sts_data_err_cnt);
        if (len_err)  sts_len_err_cnt  <= sat_inc(sts_len_err_cnt);
        if (beat_err) sts_err          <= 1'b1;
        if (s_axis.tlast) begin
          sts_pkt_cnt <= sat_inc(sts_pkt_cnt);
          if (pkt_err_cur || beat_err) sts_err_pkt_cnt <= sat_inc(sts_err_pkt_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_cmip_pkt_chk_easy.sv
// Bench for cmip_pkt_chk_easy: directed scenarios plus randomized packets,
// scored per accepted beat against a packet-level reference model.
module tb_cmip_pkt_chk_easy;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_rst;
  logic [31:0] cfg_len;
  logic [31:0] cfg_mode;
  logic [31:0] sts_pkt_cnt, sts_err_pkt_cnt, sts_len_err_cnt, sts_data_err_cnt;
  logic        sts_err, sts_err_pulse, sts_busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pkt;
    logic [31:0] err_pkt;
    logic [31:0] len_err;
    logic [31:0] data_err;
    logic        err;
    logic        pulse;
    logic        busy;
  } snap_t;

  snap_t exp_q[$];

  // Reference model state: whole-packet view driven by the beat position.
  logic [31:0] m_exp32;
  int          m_pkt, m_err_pkt, m_len_err, m_data_err;
  bit          m_err, m_pkt_bad, m_len_done;

  cmip_pkt_chk_easy_if #(.DATA_WD(32)) s_axis ();

  cmip_pkt_chk_easy #(.DATA_WD(32), .CFG_WD(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_rst          (cfg_rst),
    .cfg_len          (cfg_len),
    .cfg_mode         (cfg_mode),
    .s_axis           (s_axis.slave),
    .sts_pkt_cnt      (sts_pkt_cnt),
    .sts_err_pkt_cnt  (sts_err_pkt_cnt),
    .sts_len_err_cnt  (sts_len_err_cnt),
    .sts_data_err_cnt (sts_data_err_cnt),
    .sts_err          (sts_err),
    .sts_err_pulse    (sts_err_pulse),
    .sts_busy         (sts_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.pkt      = sts_pkt_cnt;
    s.err_pkt  = sts_err_pkt_cnt;
    s.len_err  = sts_len_err_cnt;
    s.data_err = sts_data_err_cnt;
    s.err      = sts_err;
    s.pulse    = sts_err_pulse;
    s.busy     = sts_busy;
    return s;
  endfunction

  function automatic snap_t model_snap(input bit pulse, input bit busy);
    snap_t s;
    s.pkt      = 32'(m_pkt);
    s.err_pkt  = 32'(m_err_pkt);
    s.len_err  = 32'(m_len_err);
    s.data_err = 32'(m_data_err);
    s.err      = m_err;
    s.pulse    = pulse;
    s.busy     = busy;
    return s;
  endfunction

  task automatic model_reset();
    m_exp32 = 0; m_pkt = 0; m_err_pkt = 0; m_len_err = 0; m_data_err = 0;
    m_err = 0; m_pkt_bad = 0; m_len_done = 0;
  endtask

  // Applies the checking rules to beat i of the current packet and queues
  // the status expected on the cycle after it is accepted.
  task automatic model_beat(input int i, input logic [31:0] d, input logic [3:0] keep,
                            input bit last, input bit user);
    int len_imp;
    bit derr, lerr;
    len_imp = (cfg_len == 0) ? 8 : int'(cfg_len);
    derr = 0;
    if (cfg_mode[1]) begin
      if (d != m_exp32) derr = 1;
      m_exp32 = d + 32'd1;
    end else begin
      if (d != 32'(i)) derr = 1;
      m_exp32 = 0;
    end
    if (keep != 4'hF) derr = 1;
    if (user != (i == 0)) derr = 1;
    lerr = 0;
    if (!m_len_done) begin
      if (last && i < len_imp - 1) lerr = 1;
      if (!last && i == len_imp - 1) lerr = 1;
    end
    if (lerr) m_len_done = 1;
    if (derr) m_data_err++;
    if (lerr) m_len_err++;
    if (derr || lerr) begin
      m_pkt_bad = 1;
      m_err = 1;
    end
    if (last) begin
      m_pkt++;
      if (m_pkt_bad) m_err_pkt++;
      m_pkt_bad = 0;
      m_len_done = 0;
    end
    exp_q.push_back(model_snap(derr | lerr, !last));
  endtask

  // Monitor: every accepted beat must be matched by one queued expectation.
  always @(posedge clk) begin
    if (s_axis.tvalid && s_axis.tready) begin
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat with empty queue expected none");
      end else begin
        check("beat_status", 160'(dut_snap()), 160'(exp_q.pop_front()));
      end
    end
  end

  // Presents one beat after `gap` idle cycles and holds it until accepted.
  task automatic put_beat(input int i, input logic [31:0] d, input logic [3:0] keep,
                          input bit last, input bit user, input int gap);
    bit done;
    @(negedge clk);
    if (gap > 0) begin
      s_axis.tvalid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_axis.tdata  = d;
    s_axis.tkeep  = keep;
    s_axis.tlast  = last;
    s_axis.tuser  = user;
    s_axis.tvalid = 1'b1;
    done = 0;
    for (int t = 0; t < 16 && !done; t++) begin
      #1;
      if (s_axis.tready) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got tready low for 16 cycles expected accept");
      s_axis.tvalid = 1'b0;
    end else begin
      model_beat(i, d, keep, last, user);
      @(posedge clk);
    end
  endtask

  function automatic logic [31:0] pattern(input int i);
    return cfg_mode[1] ? m_exp32 : 32'(i);
  endfunction

  task automatic send_clean(input int nb);
    for (int i = 0; i < nb; i++)
      put_beat(i, pattern(i), 4'hF, i == nb - 1, i == 0, 0);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string name, input int pkt, input int err_pkt,
                              input int len_err, input int data_err, input bit err);
    snap_t e;
    e.pkt = 32'(pkt); e.err_pkt = 32'(err_pkt); e.len_err = 32'(len_err);
    e.data_err = 32'(data_err); e.err = err; e.pulse = 1'b0; e.busy = 1'b0;
    check(name, 160'(dut_snap()), 160'(e));
  endtask

  task automatic do_cfg_rst();
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    cfg_rst = 1'b1;
    #1;
    check("cfg_rst_tready_low", 160'(s_axis.tready), 160'(0));
    @(negedge clk);
    cfg_rst = 1'b0;
    model_reset();
    #1;
    check_status("cfg_rst_clear", 0, 0, 0, 0, 0);
    check("cfg_rst_tready_high", 160'(s_axis.tready), 160'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats;
    int kb;
    int nb;
    int li;
    logic [31:0] d;

    rst = 1'b1; cfg_rst = 1'b0; cfg_len = 0; cfg_mode = 0;
    s_axis.tvalid = 1'b0; s_axis.tdata = 0; s_axis.tkeep = 0;
    s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    model_reset();

    // Reset behaviour.
    repeat (3) @(negedge clk);
    check("rst_tready_low", 160'(s_axis.tready), 160'(0));
    check_status("rst_status", 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("rst_tready_high", 160'(s_axis.tready), 160'(1));
    check_status("post_rst_status", 0, 0, 0, 0, 0);

    // Mode 0, default length: three clean 8-beat packets.
    repeat (3) send_clean(8);
    idle(2);
    check_status("t1_clean", 3, 0, 0, 0, 0);

    // Running counter, 4-beat packets, then a gap in the sequence.
    do_cfg_rst();
    @(negedge clk); cfg_len = 4; cfg_mode = 32'h2;
    send_clean(4);
    send_clean(4);
    for (int i = 0; i < 4; i++) put_beat(i, 32'(10 + i), 4'hF, i == 3, i == 0, 0);
    idle(2);
    check_status("t2_counter_gap", 3, 1, 0, 1, 1);

    // Short then long packet with cfg_len=5.
    do_cfg_rst();
    @(negedge clk); cfg_len = 5; cfg_mode = 0;
    send_clean(3);
    send_clean(7);
    idle(2);
    check_status("t3_length", 2, 2, 2, 0, 1);

    // Bad keep on beat 2, extra SOP on beat 1; sticky flag holds.
    do_cfg_rst();
    @(negedge clk); cfg_len = 0; cfg_mode = 0;
    for (int i = 0; i < 8; i++)
      put_beat(i, 32'(i), (i == 2) ? 4'hE : 4'hF, i == 7, i <= 1, 0);
    idle(2);
    check_status("t4_keep_sop", 1, 1, 0, 2, 1);
    send_clean(8);
    idle(3);
    check("t4_sticky", 160'(sts_err), 160'(1));

    // Discard a packet by cfg_rst after three beats.
    do_cfg_rst();
    for (int i = 0; i < 3; i++) put_beat(i, 32'(i), 4'hF, 1'b0, i == 0, 0);
    idle(1);
    check("t6_busy_mid", 160'(sts_busy), 160'(1));
    do_cfg_rst();
    send_clean(8);
    idle(2);
    check_status("t6_after_discard", 1, 0, 0, 0, 0);

    // Backpressure: source always valid for 100 cycles, 5-beat packets.
    do_cfg_rst();
    @(negedge clk); cfg_len = 5;
    beats = 0;
    kb = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) cfg_mode = 32'h4;
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = 32'(kb);
      s_axis.tkeep  = 4'hF;
      s_axis.tlast  = (kb == 4);
      s_axis.tuser  = (kb == 0);
      #1;
      check("bp_ready_phase", 160'(s_axis.tready), 160'((k % 4) != 3));
      if (s_axis.tready) begin
        model_beat(kb, 32'(kb), 4'hF, kb == 4, kb == 0);
        beats++;
        kb = (kb + 1) % 5;
      end
    end
    idle(2);
    check("bp_beat_count", 160'(beats), 160'(75));
    check_status("bp_status", 15, 0, 0, 0, 0);

    // Randomized packets: lengths around the configured one, rare corruptions.
    do_cfg_rst();
    for (int p = 0; p < 40; p++) begin
      @(negedge clk);
      s_axis.tvalid = 1'b0;
      cfg_len  = $urandom_range(0, 6);
      cfg_mode = {29'($urandom), 3'($urandom_range(0, 3) << 1)} | ($urandom_range(0, 1) ? 32'h1 : 32'h0);
      if (!cfg_mode[1]) m_exp32 = 0;
      li = (cfg_len == 0) ? 8 : int'(cfg_len);
      nb = li - 2 + int'($urandom_range(0, 4));
      if (nb < 1) nb = 1;
      for (int i = 0; i < nb; i++) begin
        d = pattern(i);
        if ($urandom_range(0, 19) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
        put_beat(i, d,
                 ($urandom_range(0, 19) == 0) ? 4'h7 : 4'hF,
                 i == nb - 1,
                 (i == 0) ^ ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end
    idle(3);
    check_status("rand_final", m_pkt, m_err_pkt, m_len_err, m_data_err, m_err);
    check("queue_drained", 160'(exp_q.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmip_pkt_chk_easy.md
# cmip_pkt_chk_easy

AXI-stream packet checker that sits directly downstream of the team's easy packet generator on the Aurora loopback/test path. It consumes generated packets and verifies length, SOP marking, keep and payload pattern against the same configuration the generator uses. It also exposes saturating packet and error counters plus a sticky error flag for register readback. It can optionally throttle `s_axis_tready` to exercise upstream backpressure handling.

## Interface
- `DATA_WD`, 32, stream data width (multiple of 8, ≥32)
- `CFG_WD`, 32, configuration/status word width
- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset
- `cfg_rst`  in  1  synchronous clear of state, expected-pattern seed and all status; same effect as `rst`
- `cfg_len`  in  CFG_WD  expected beats per packet; 0 means 8
- `cfg_mode`  in  CFG_WD  bit1: pattern select (0 = beat index, 1 = running 32-bit counter); bit2: backpressure enable; other bits ignored
- `s_axis_tdata`  in  DATA_WD  payload
- `s_axis_tkeep`  in  DATA_WD/8  byte enables; all ones required
- `s_axis_tvalid`  in  1  beat valid
- `s_axis_tready`  out  1  beat accept
- `s_axis_tlast`  in  1  last beat of packet
- `s_axis_tuser`  in  1  SOP marker; required on first beat only
- `sts_pkt_cnt`  out  CFG_WD  packets completed (tlast accepted)
- `sts_err_pkt_cnt`  out  CFG_WD  completed packets containing ≥1 error
- `sts_len_err_cnt`  out  CFG_WD  length errors
- `sts_data_err_cnt`  out  CFG_WD  payload, keep or SOP errors (one per bad beat)
- `sts_err`  out  1  sticky: any error since reset/cfg_rst
- `sts_err_pulse`  out  1  one-cycle pulse per beat with ≥1 new error
- `sts_busy`  out  1  high while inside a packet (state PKT)

## Operation
- Handshake: beat accepted when `s_axis_tvalid && s_axis_tready`; nothing is evaluated on non-accepted cycles.
- `len_imp = (cfg_len==0) ? 8 : cfg_len`.
- FSM, 2 states:
  - IDLE: waiting for first beat; accepted beat → index 0 is checked; if tlast also set → stay IDLE (one-beat packet), else → PKT.
  - PKT: accepted beat checked at current index; tlast → IDLE.
- Beat index `idx` (CFG_WD bits): 0 on first beat, +1 per accepted beat, cleared on tlast; saturates at all-ones.
- Expected data:
  - mode1=0: low 32 bits of tdata == idx[31:0]; upper bits ignored.
  - mode1=1: low 32 bits == `exp32`; `exp32` increments per accepted beat. On mismatch `exp32` reloads to received+1, so a single gap counts one error. `exp32` forced to 0 while mode1=0 and on reset/cfg_rst.
- Per-beat data checks (each bad beat adds 1 to `sts_data_err_cnt` even if several fail): payload mismatch; tkeep not all ones; tuser≠(idx==0).
- Length checks (max 1 per packet):
  - Short: tlast with idx < len_imp-1.
  - Long: beat at idx == len_imp-1 without tlast; flagged on that beat; later beats of the packet add no further length errors.
- Packet error flag is set by any error in the packet. On the tlast beat `sts_pkt_cnt`+1, and `sts_err_pkt_cnt`+1 if the flag (including this beat's errors) is set; the flag is then cleared.
- All counters saturate at all-ones; no wrap.
- Backpressure: 2-bit free-running counter `bp`, reset 0, increments every cycle while mode2=1, held at 0 otherwise. `s_axis_tready = ~rst & ~cfg_rst & ~(mode2 & bp==3)`.
- Config changes mid-packet take effect on the next accepted beat; no resync.

## Timing
- Reset/cfg_rst values: all counters 0, `sts_err`=0, `sts_err_pulse`=0, `sts_busy`=0, FSM IDLE, `s_axis_tready`=0 during the reset cycle, 1 on the first cycle after (mode2=0).
- All status outputs are registered: they update the cycle after the accepted beat that caused the change. `sts_err_pulse` is high for exactly that one cycle.
- `cfg_rst` asserted mid-packet: packet is discarded uncounted; the next accepted beat is treated as a first beat.
- With mode2=1, tready is low 1 cycle in 4 (cycles where bp==3); throughput is 3/4.

## Test plan
- Mode 0, cfg_len=0, 3 clean packets of 8 beats (data 0..7, tuser on beat 0) → pkt_cnt=3, all error counts 0, sts_err=0.
- Mode1=1, cfg_len=4, 2 packets with data 0..3, 4..7; then a packet with data 10..13 → pkt_cnt=3, data_err_cnt=1 (beat with data 10), err_pkt_cnt=1.
- cfg_len=5: a 3-beat packet, then a 7-beat packet → len_err_cnt=2, err_pkt_cnt=2, sts_err pulse on beat 2 of pkt 1 and on beat 4 of pkt 2.
- Clean packet with tkeep=0xE on beat 2 and tuser on beat 1 → data_err_cnt=2, err_pkt_cnt=1, sts_err sticky until cfg_rst.
- mode2=1, source always valid, 100 cycles → tready low on exactly every 4th cycle, no errors, beat count 75.
- cfg_rst on beat 3 of an 8-beat packet, then 1 clean packet → all counters 0 then pkt_cnt=1, no errors.
